onchip_mem_arbiter: RTL and testbench

Two-requester Avalon-MM arbiter sharing the single-port 64K x 32 on-chip RAM. Port m0 is the Nios II data master and port m1 is the touch/Wi-Fi stroke DMA. The block grants at most one transfer per cycle, using round-robin with an optional lock for read-modify-write sequences. It routes each 1-cycle-latency read return back to the port that issued it, and it drives the RAM's address, byteenable, chipselect, write, writedata and clken inputs directly.

---
 rtl/onchip_mem_arbiter_if.sv | 33 +++
 rtl/onchip_mem_arbiter.sv | 132 +++++++++++++
 tb/tb_onchip_mem_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/onchip_mem_arbiter_if.sv
// ============================================================================
//  Module   : onchip_mem_arbiter_if
//  Brief    : Avalon-MM requester port bundle used between a master and the arbiter.
//  Revision : 1.0
// ============================================================================
`default_nettype none

interface onchip_mem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   address;
    logic [DATA_W/8-1:0] byteenable;
    logic                read;
    logic                write;
    logic [DATA_W-1:0]   writedata;
    logic                lock;
    logic                waitrequest;
    logic [DATA_W-1:0]   readdata;
    logic                readdatavalid;

    modport master (
        output address, byteenable, read, write, writedata, lock,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  address, byteenable, read, write, writedata, lock,
        output waitrequest, readdata, readdatavalid
    );
endinterface

`default_nettype wire

// File: rtl/onchip_mem_arbiter.sv
// ============================================================================
//  Module   : onchip_mem_arbiter
//  Brief    : Round-robin two-port arbiter with lock for a 1-cycle-latency RAM.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module onchip_mem_arbiter #(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 32,
    parameter int LOCK_TIMEOUT = 64
) (
    input  wire                   clk,
    input  wire                   reset,
    input  wire                   reset_req,
    onchip_mem_arbiter_if.slave   m0,
    onchip_mem_arbiter_if.slave   m1,
    output logic [ADDR_W-1:0]     mem_address,
    output logic [DATA_W/8-1:0]   mem_byteenable,
    output logic [DATA_W-1:0]     mem_writedata,
    output logic                  mem_chipselect,
    output logic                  mem_write,
    output logic                  mem_clken,
    input  wire  [DATA_W-1:0]     mem_readdata
);
    localparam int         c_be_w     = DATA_W / 8;
    localparam logic [7:0] c_idle_max = 8'(LOCK_TIMEOUT - 1);

    logic                w_req0;
    logic                w_req1;
    logic                w_owner_req;
    logic                w_gnt_v;
    logic                w_gnt_id;
    logic [ADDR_W-1:0]   w_sel_address;
    logic [c_be_w-1:0]   w_sel_byteenable;
    logic [DATA_W-1:0]   w_sel_writedata;
    logic                w_sel_read;
    logic                w_sel_write;
    logic                w_sel_lock;

    logic                r_last_grant;
    logic                r_lock_v;
    logic                r_lock_id;
    logic [7:0]          r_idle_cnt;
    logic                r_rd_pend_v;
    logic                r_rd_pend_id;
    logic [ADDR_W-1:0]   r_addr_hold;

    assign w_req0      = m0.read | m0.write;
    assign w_req1      = m1.read | m1.write;
    assign w_owner_req = r_lock_id ? w_req1 : w_req0;

    always_comb begin
        w_gnt_v  = 1'b0;
        w_gnt_id = 1'b0;
        if (!reset_req) begin
            if (r_lock_v) begin
                w_gnt_v  = w_owner_req;
                w_gnt_id = r_lock_id;
            end else if (w_req0 && w_req1) begin
                w_gnt_v  = 1'b1;
                w_gnt_id = ~r_last_grant;
            end else if (w_req0 || w_req1) begin
                w_gnt_v  = 1'b1;
                w_gnt_id = w_req1;
            end
        end
    end

    assign w_sel_address    = w_gnt_id ? m1.address    : m0.address;
    assign w_sel_byteenable = w_gnt_id ? m1.byteenable : m0.byteenable;
    assign w_sel_writedata  = w_gnt_id ? m1.writedata  : m0.writedata;
    assign w_sel_read       = w_gnt_id ? m1.read       : m0.read;
    assign w_sel_write      = w_gnt_id ? m1.write      : m0.write;
    assign w_sel_lock       = w_gnt_id ? m1.lock       : m0.lock;

    assign mem_chipselect = w_gnt_v;
    assign mem_write      = w_gnt_v & w_sel_write;
    assign mem_address    = w_gnt_v ? w_sel_address : r_addr_hold;
    assign mem_byteenable = w_sel_read ? {c_be_w{1'b1}} : w_sel_byteenable;
    assign mem_writedata  = w_sel_writedata;
    assign mem_clken      = ~reset_req;

    assign m0.waitrequest   = w_gnt_v ? w_gnt_id : w_req0;
    assign m1.waitrequest   = w_gnt_v ? ~w_gnt_id : w_req1;
    assign m0.readdata      = mem_readdata;
    assign m1.readdata      = mem_readdata;
    assign m0.readdatavalid = r_rd_pend_v & ~r_rd_pend_id;
    assign m1.readdatavalid = r_rd_pend_v & r_rd_pend_id;

    // Address is held across idle cycles so the RAM input never glitches
    always_ff @(posedge clk) begin
        if (w_gnt_v) begin
            r_addr_hold <= w_sel_address;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_grant <= 1'b1;
            r_lock_v     <= 1'b0;
            r_lock_id    <= 1'b0;
            r_idle_cnt   <= 8'd0;
            r_rd_pend_v  <= 1'b0;
            r_rd_pend_id <= 1'b0;
        end else begin
            r_rd_pend_v  <= w_gnt_v & w_sel_read;
            r_rd_pend_id <= w_gnt_id;
            if (w_gnt_v) begin
                r_last_grant <= w_gnt_id;
            end

            // A grant while locked can only be the owner, so it ends the lock unless renewed
            if (w_gnt_v && w_sel_lock) begin
                r_lock_v  <= 1'b1;
                r_lock_id <= w_gnt_id;
            end else if (w_gnt_v && r_lock_v) begin
                r_lock_v <= 1'b0;
            end else if (r_lock_v && !w_owner_req && r_idle_cnt == c_idle_max) begin
                r_lock_v <= 1'b0;
            end

            if (!r_lock_v || w_owner_req || r_idle_cnt == c_idle_max) begin
                r_idle_cnt <= 8'd0;
            end else begin
                r_idle_cnt <= r_idle_cnt + 8'd1;
            end
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_onchip_mem_arbiter.sv
// ============================================================================
//  Module   : tb_onchip_mem_arbiter
//  Brief    : Directed and randomized checks of the arbiter against a cycle model.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_onchip_mem_arbiter;
    localparam int ADDR_W       = 16;
    localparam int DATA_W       = 32;
    localparam int LOCK_TIMEOUT = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              reset_req;
    logic [ADDR_W-1:0] mem_address;
    logic [3:0]        mem_byteenable;
    logic [31:0]       mem_writedata;
    logic              mem_chipselect;
    logic              mem_write;
    logic              mem_clken;
    logic [31:0]       mem_readdata;

    onchip_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m0_if ();
    onchip_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m1_if ();

    always #5 clk = ~clk;

    onchip_mem_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LOCK_TIMEOUT(LOCK_TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset), .reset_req(reset_req),
        .m0(m0_if.slave), .m1(m1_if.slave),
        .mem_address(mem_address), .mem_byteenable(mem_byteenable),
        .mem_writedata(mem_writedata), .mem_chipselect(mem_chipselect),
        .mem_write(mem_write), .mem_clken(mem_clken), .mem_readdata(mem_readdata)
    );

    // On-chip RAM: registered address, combinational q from the held address
    bit   [31:0] ram [0:65535];
    logic [15:0] ram_addr_q = 16'h0;
    always @(posedge clk) begin
        if (mem_clken) begin
            ram_addr_q <= mem_address;
            if (mem_chipselect && mem_write)
                for (int b = 0; b < 4; b++)
                    if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
        end
    end
    assign mem_readdata = ram[ram_addr_q];

    int checks = 0;
    int errors = 0;

    // Reference model state
    int          md_last    = 1;
    bit          md_lock_v  = 0;
    int          md_lock_id = 0;
    int          md_idle    = 0;
    bit          md_rdv [2];
    logic [31:0] md_rdata;
    logic [15:0] md_hold;
    bit          md_hold_known = 0;
    bit   [31:0] shadow [0:65535];

    function automatic bit rd_of(int k);  return (k == 0) ? m0_if.read : m1_if.read; endfunction
    function automatic bit wr_of(int k);  return (k == 0) ? m0_if.write : m1_if.write; endfunction
    function automatic bit lk_of(int k);  return (k == 0) ? m0_if.lock : m1_if.lock; endfunction
    function automatic bit req_of(int k); return rd_of(k) | wr_of(k); endfunction
    function automatic logic [15:0] addr_of(int k); return (k == 0) ? m0_if.address : m1_if.address; endfunction
    function automatic logic [3:0]  be_of(int k);   return (k == 0) ? m0_if.byteenable : m1_if.byteenable; endfunction
    function automatic logic [31:0] wd_of(int k);   return (k == 0) ? m0_if.writedata : m1_if.writedata; endfunction

    // Who the rules say is served this cycle; -1 means nobody
    function automatic int model_grant();
        if (reset_req) return -1;
        if (md_lock_v) return req_of(md_lock_id) ? md_lock_id : -1;
        if (req_of(0) && req_of(1)) return 1 - md_last;
        if (req_of(0)) return 0;
        if (req_of(1)) return 1;
        return -1;
    endfunction

    task automatic drive(input int k, input bit rd, input bit wr, input logic [15:0] a,
                         input logic [3:0] be, input logic [31:0] wd, input bit lk);
        if (k == 0) begin
            m0_if.read = rd; m0_if.write = wr; m0_if.address = a;
            m0_if.byteenable = be; m0_if.writedata = wd; m0_if.lock = lk;
        end else begin
            m1_if.read = rd; m1_if.write = wr; m1_if.address = a;
            m1_if.byteenable = be; m1_if.writedata = wd; m1_if.lock = lk;
        end
    endtask

    task automatic idle_all();
        drive(0, 1'b0, 1'b0, 16'h0, 4'h0, 32'h0, 1'b0);
        drive(1, 1'b0, 1'b0, 16'h0, 4'h0, 32'h0, 1'b0);
    endtask

    // Advance the model by the transfer the rules select, then step the clock
    task automatic tick();
        int g;
        logic [15:0] a;
        g = model_grant();
        if (reset) begin
            md_last = 1; md_lock_v = 0; md_lock_id = 0; md_idle = 0;
            md_rdv[0] = 0; md_rdv[1] = 0;
        end else begin
            md_rdv[0] = 0; md_rdv[1] = 0;
            if (g >= 0) begin
                a = addr_of(g);
                md_last = g; md_hold = a; md_hold_known = 1;
                if (rd_of(g)) begin md_rdv[g] = 1; md_rdata = shadow[a]; end
                if (wr_of(g))
                    for (int b = 0; b < 4; b++)
                        if (be_of(g)[b]) shadow[a][8*b +: 8] = wd_of(g)[8*b +: 8];
                if (lk_of(g)) begin md_lock_v = 1; md_lock_id = g; end
                else md_lock_v = 0;
                md_idle = 0;
            end else if (md_lock_v) begin
                if (req_of(md_lock_id)) md_idle = 0;
                else begin
                    md_idle++;
                    if (md_idle == LOCK_TIMEOUT) begin md_lock_v = 0; md_idle = 0; end
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_all();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset_req = 1'b0;
        do_reset();
        #1;
        checks++; if (m0_if.readdatavalid !== 1'b0) begin errors++; $display("FAIL reset_rdv0 got %b want 0", m0_if.readdatavalid); end
        checks++; if (m1_if.readdatavalid !== 1'b0) begin errors++; $display("FAIL reset_rdv1 got %b want 0", m1_if.readdatavalid); end
        checks++; if (mem_chipselect !== 1'b0) begin errors++; $display("FAIL reset_cs got %b want 0", mem_chipselect); end
        checks++; if (mem_clken !== 1'b1) begin errors++; $display("FAIL reset_clken got %b want 1", mem_clken); end
        checks++; if ({m0_if.waitrequest, m1_if.waitrequest} !== 2'b00) begin errors++; $display("FAIL reset_wait got %b want 00", {m0_if.waitrequest, m1_if.waitrequest}); end
    endtask

    task automatic test_write_read();
        drive(0, 1'b0, 1'b1, 16'h0010, 4'hF, 32'hDEADBEEF, 1'b0);
        drive(1, 1'b0, 1'b0, 16'h0, 4'h0, 32'h0, 1'b0);
        #1;
        checks++; if (m0_if.waitrequest !== 1'b0) begin errors++; $display("FAIL wr_m0_wait got %b want 0", m0_if.waitrequest); end
        checks++; if (m1_if.waitrequest !== 1'b1) begin errors++; $display("FAIL wr_m1_wait got %b want 1", m1_if.waitrequest); end
        checks++; if (mem_write !== 1'b1) begin errors++; $display("FAIL wr_mem_write got %b want 1", mem_write); end
        checks++; if (mem_address !== 16'h0010) begin errors++; $display("FAIL wr_addr got %h want 0010", mem_address); end
        tick();
        drive(0, 1'b0, 1'b0, 16'h0, 4'h0, 32'h0, 1'b0);
        drive(1, 1'b1, 1'b0, 16'h0010, 4'h3, 32'h0, 1'b0);
        #1;
        checks++; if (m1_if.waitrequest !== 1'b0) begin errors++; $display("FAIL rd_m1_wait got %b want 0", m1_if.waitrequest); end
        checks++; if (mem_byteenable !== 4'hF) begin errors++; $display("FAIL rd_be got %h want f", mem_byteenable); end
        tick();
        idle_all();
        #1;
        checks++; if (m1_if.readdatavalid !== 1'b1) begin errors++; $display("FAIL rd_m1_rdv got %b want 1", m1_if.readdatavalid); end
        checks++; if (m1_if.readdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_m1_data got %h want deadbeef", m1_if.readdata); end
        checks++; if (m0_if.readdatavalid !== 1'b0) begin errors++; $display("FAIL rd_m0_rdv got %b want 0", m0_if.readdatavalid); end
        tick();
    endtask

    task automatic test_back_to_back();
        int n0, n1, prev, exp_id;
        logic [31:0] prev_data;
        for (int i = 0; i < 6; i++) begin
            drive(0, 1'b0, 1'b1, 16'(32 + i), 4'hF, 32'hA0000000 | 32'(32 + i), 1'b0); tick();
            drive(0, 1'b0, 1'b1, 16'(64 + i), 4'hF, 32'hA0000000 | 32'(64 + i), 1'b0); tick();
        end
        do_reset();
        n0 = 0; n1 = 0; prev = -1; prev_data = 32'h0;
        for (int c = 0; c < 7; c++) begin
            if (c < 6) begin
                drive(0, 1'b1, 1'b0, 16'(32 + n0), 4'h0, 32'h0, 1'b0);
                drive(1, 1'b1, 1'b0, 16'(64 + n1), 4'h0, 32'h0, 1'b0);
            end else idle_all();
            #1;
            exp_id = c % 2;
            if (c < 6) begin
                checks++; if (m0_if.waitrequest !== (exp_id != 0)) begin errors++; $display("FAIL b2b_m0_wait c%0d got %b want %b", c, m0_if.waitrequest, exp_id != 0); end
                checks++; if (m1_if.waitrequest !== (exp_id != 1)) begin errors++; $display("FAIL b2b_m1_wait c%0d got %b want %b", c, m1_if.waitrequest, exp_id != 1); end
            end
            checks++; if (m0_if.readdatavalid !== (prev == 0)) begin errors++; $display("FAIL b2b_m0_rdv c%0d got %b want %b", c, m0_if.readdatavalid, prev == 0); end
            checks++; if (m1_if.readdatavalid !== (prev == 1)) begin errors++; $display("FAIL b2b_m1_rdv c%0d got %b want %b", c, m1_if.readdatavalid, prev == 1); end
            if (prev >= 0) begin
                checks++; if (mem_readdata !== prev_data) begin errors++; $display("FAIL b2b_data c%0d got %h want %h", c, mem_readdata, prev_data); end
            end
            if (c < 6) begin
                prev = exp_id;
                if (exp_id == 0) begin prev_data = 32'hA0000000 | 32'(32 + n0); n0++; end
                else begin prev_data = 32'hA0000000 | 32'(64 + n1); n1++; end
            end
            tick();
        end
    endtask

    task automatic test_lock();
        do_reset();
        drive(0, 1'b1, 1'b0, 16'h0020, 4'h0, 32'h0, 1'b1);
        drive(1, 1'b1, 1'b0, 16'h0040, 4'h0, 32'h0, 1'b0);
        #1;
        checks++; if ({m0_if.waitrequest, m1_if.waitrequest} !== 2'b01) begin errors++; $display("FAIL lock_c0 wait got %b want 01", {m0_if.waitrequest, m1_if.waitrequest}); end
        tick();
        drive(0, 1'b0, 1'b1, 16'h0030, 4'hF, 32'h00001234, 1'b0);
        #1;
        checks++; if ({m0_if.waitrequest, m1_if.waitrequest} !== 2'b01) begin errors++; $display("FAIL lock_c1 wait got %b want 01", {m0_if.waitrequest, m1_if.waitrequest}); end
        checks++; if (m0_if.readdatavalid !== 1'b1 || m0_if.readdata !== 32'hA0000020) begin errors++; $display("FAIL lock_c1 rdv/data got %b/%h want 1/a0000020", m0_if.readdatavalid, m0_if.readdata); end
        tick();
        drive(0, 1'b1, 1'b0, 16'h0021, 4'h0, 32'h0, 1'b0);
        #1;
        checks++; if ({m0_if.waitrequest, m1_if.waitrequest} !== 2'b10) begin errors++; $display("FAIL lock_c2 wait got %b want 10", {m0_if.waitrequest, m1_if.waitrequest}); end
        tick();
        drive(1, 1'b0, 1'b0, 16'h0, 4'h0, 32'h0, 1'b0);
        #1;
        checks++; if (m0_if.waitrequest !== 1'b0) begin errors++; $display("FAIL lock_c3 m0_wait got %b want 0", m0_if.waitrequest); end
        checks++; if (m1_if.readdatavalid !== 1'b1 || m1_if.readdata !== 32'hA0000040) begin errors++; $display("FAIL lock_c3 rdv/data got %b/%h want 1/a0000040", m1_if.readdatavalid, m1_if.readdata); end
        tick();
        idle_all();
    endtask

    task automatic test_lock_timeout();
        do_reset();
        drive(1, 1'b1, 1'b0, 16'h0040, 4'h0, 32'h0, 1'b1);
        #1;
        checks++; if (m1_if.waitrequest !== 1'b0) begin errors++; $display("FAIL tmo_m1_wait got %b want 0", m1_if.waitrequest); end
        tick();
        drive(1, 1'b0, 1'b0, 16'h0, 4'h0, 32'h0, 1'b0);
        drive(0, 1'b1, 1'b0, 16'h0020, 4'h0, 32'h0, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            #1;
            checks++; if (m0_if.waitrequest !== (k < 5)) begin errors++; $display("FAIL tmo_m0_wait k%0d got %b want %b", k, m0_if.waitrequest, k < 5); end
            tick();
        end
        idle_all();
    endtask

    task automatic test_reset_req();
        do_reset();
        drive(0, 1'b1, 1'b0, 16'h0010, 4'h0, 32'h0, 1'b0);
        #1;
        checks++; if (m0_if.waitrequest !== 1'b0) begin errors++; $display("FAIL rreq_c0_wait got %b want 0", m0_if.waitrequest); end
        tick();
        reset_req = 1'b1;
        drive(0, 1'b1, 1'b0, 16'h0020, 4'h0, 32'h0, 1'b0);
        drive(1, 1'b1, 1'b0, 16'h0040, 4'h0, 32'h0, 1'b0);
        for (int c = 1; c <= 3; c++) begin
            #1;
            checks++; if ({m0_if.waitrequest, m1_if.waitrequest} !== 2'b11) begin errors++; $display("FAIL rreq_wait c%0d got %b want 11", c, {m0_if.waitrequest, m1_if.waitrequest}); end
            checks++; if ({mem_chipselect, mem_clken} !== 2'b00) begin errors++; $display("FAIL rreq_cs_clken c%0d got %b want 00", c, {mem_chipselect, mem_clken}); end
            checks++; if (m0_if.readdatavalid !== (c == 1)) begin errors++; $display("FAIL rreq_rdv c%0d got %b want %b", c, m0_if.readdatavalid, c == 1); end
            if (c == 1) begin
                checks++; if (m0_if.readdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rreq_data got %h want deadbeef", m0_if.readdata); end
            end
            tick();
        end
        reset_req = 1'b0;
        idle_all();
        tick();
    endtask

    task automatic test_sync_reset();
        do_reset();
        drive(1, 1'b1, 1'b0, 16'h0040, 4'h0, 32'h0, 1'b1);
        tick();
        drive(1, 1'b1, 1'b0, 16'h0041, 4'h0, 32'h0, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        drive(0, 1'b1, 1'b0, 16'h0020, 4'h0, 32'h0, 1'b0);
        drive(1, 1'b1, 1'b0, 16'h0040, 4'h0, 32'h0, 1'b0);
        #1;
        checks++; if ({m0_if.readdatavalid, m1_if.readdatavalid} !== 2'b00) begin errors++; $display("FAIL srst_rdv got %b want 00", {m0_if.readdatavalid, m1_if.readdatavalid}); end
        checks++; if ({m0_if.waitrequest, m1_if.waitrequest} !== 2'b01) begin errors++; $display("FAIL srst_grant wait got %b want 01", {m0_if.waitrequest, m1_if.waitrequest}); end
        tick();
        idle_all();
        tick();
    endtask

    task automatic test_random();
        int g, op;
        logic e0, e1;
        for (int n = 0; n < 600; n++) begin
            for (int k = 0; k < 2; k++) begin
                op = $urandom_range(0, 2);
                drive(k, op == 1, op == 2, 16'($urandom_range(0, 31)), 4'($urandom), $urandom,
                      $urandom_range(0, 5) == 0);
            end
            reset_req = ($urandom_range(0, 15) == 0);
            #1;
            g  = model_grant();
            e0 = (g == 0) ? 1'b0 : (g == 1) ? 1'b1 : req_of(0);
            e1 = (g == 1) ? 1'b0 : (g == 0) ? 1'b1 : req_of(1);
            checks++; if (m0_if.waitrequest !== e0) begin errors++; $display("FAIL rnd_m0_wait n%0d got %b want %b", n, m0_if.waitrequest, e0); end
            checks++; if (m1_if.waitrequest !== e1) begin errors++; $display("FAIL rnd_m1_wait n%0d got %b want %b", n, m1_if.waitrequest, e1); end
            checks++; if (mem_chipselect !== (g >= 0)) begin errors++; $display("FAIL rnd_cs n%0d got %b want %b", n, mem_chipselect, g >= 0); end
            checks++; if (mem_write !== (g >= 0 && wr_of(g))) begin errors++; $display("FAIL rnd_write n%0d got %b want %b", n, mem_write, g >= 0 && wr_of(g)); end
            checks++; if (mem_clken !== !reset_req) begin errors++; $display("FAIL rnd_clken n%0d got %b want %b", n, mem_clken, !reset_req); end
            if (g >= 0) begin
                checks++; if (mem_address !== addr_of(g)) begin errors++; $display("FAIL rnd_addr n%0d got %h want %h", n, mem_address, addr_of(g)); end
                checks++; if (mem_byteenable !== (rd_of(g) ? 4'hF : be_of(g))) begin errors++; $display("FAIL rnd_be n%0d got %h want %h", n, mem_byteenable, rd_of(g) ? 4'hF : be_of(g)); end
                if (wr_of(g)) begin
                    checks++; if (mem_writedata !== wd_of(g)) begin errors++; $display("FAIL rnd_wdata n%0d got %h want %h", n, mem_writedata, wd_of(g)); end
                end
            end else if (md_hold_known) begin
                checks++; if (mem_address !== md_hold) begin errors++; $display("FAIL rnd_addr_hold n%0d got %h want %h", n, mem_address, md_hold); end
            end
            checks++; if (m0_if.readdatavalid !== md_rdv[0]) begin errors++; $display("FAIL rnd_m0_rdv n%0d got %b want %b", n, m0_if.readdatavalid, md_rdv[0]); end
            checks++; if (m1_if.readdatavalid !== md_rdv[1]) begin errors++; $display("FAIL rnd_m1_rdv n%0d got %b want %b", n, m1_if.readdatavalid, md_rdv[1]); end
            if (md_rdv[0] || md_rdv[1]) begin
                checks++; if ((md_rdv[0] ? m0_if.readdata : m1_if.readdata) !== md_rdata) begin errors++; $display("FAIL rnd_rdata n%0d got %h want %h", n, md_rdv[0] ? m0_if.readdata : m1_if.readdata, md_rdata); end
            end
            tick();
        end
        reset_req = 1'b0;
        idle_all();
        tick();
    endtask

    initial begin
        reset     = 1'b1;
        reset_req = 1'b0;
        idle_all();
        test_reset();
        test_write_read();
        test_back_to_back();
        test_lock();
        test_lock_timeout();
        test_reset_req();
        test_sync_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

`default_nettype wire
